// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared sizes, payload types and slot states for the vector core switch
package switch_pkg;

    localparam int SWITCH_CORE_SIZE      = 4;
    localparam int SWITCH_WIDTH          = 16;
    localparam int WORD_BITS             = 32;
    localparam int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE);

    typedef logic [WORD_BITS-1:0] word_t;
    typedef word_t [SWITCH_WIDTH-1:0] payload_t;

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        ACK
    } slot_state_t;

endpackage

// File: rtl/vec_switch_slot.sv
// rtl/vec_switch_slot.sv - one-entry holding slot for a single source core
module vec_switch_slot
    import switch_pkg::*;
(
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   send_ready,
    input  logic [SWITCH_CORE_ADDR_SIZE-1:0]       send_dst,
    input  logic [SWITCH_WIDTH-1:0][WORD_BITS-1:0] send_data,
    input  logic                                   take,
    output logic                                   full,
    output logic [SWITCH_CORE_ADDR_SIZE-1:0]       dst,
    output logic [SWITCH_WIDTH-1:0][WORD_BITS-1:0] data,
    output logic                                   send_ok
);

    slot_state_t state;

    // Once FULL the slot is the captured copy; the source's live inputs are ignored until the slot empties.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= EMPTY;
            send_ok <= 1'b0;
            dst     <= '0;
            data    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    send_ok <= 1'b0;
                    if (send_ready) begin
                        dst   <= send_dst;
                        data  <= send_data;
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (take) begin
                        state   <= ACK;
                        send_ok <= 1'b1;
                    end
                end
                ACK: begin
                    state   <= EMPTY;
                    send_ok <= 1'b0;
                end
                default: begin
                    state   <= EMPTY;
                    send_ok <= 1'b0;
                end
            endcase
        end
    end

    assign full = (state == FULL);

endmodule

// File: rtl/vec_switch.sv
// rtl/vec_switch.sv - receiver-driven inter-core payload switch for the vector cluster
module vec_switch
    import switch_pkg::*;
(
    input  logic                                                         clock,
    input  logic                                                         reset,
    input  logic [SWITCH_CORE_SIZE-1:0]                                  switch_send_ready,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]       switch_send_core_idx,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][WORD_BITS-1:0] switch_send_data,
    output logic [SWITCH_CORE_SIZE-1:0]                                  switch_send_ok,
    input  logic [SWITCH_CORE_SIZE-1:0]                                  switch_recv_request,
    input  logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0]       switch_recv_core_idx,
    output logic [SWITCH_CORE_SIZE-1:0]                                  switch_recv_ready,
    output logic [SWITCH_CORE_SIZE-1:0][SWITCH_WIDTH-1:0][WORD_BITS-1:0] switch_recv_data
);

    logic [SWITCH_CORE_SIZE-1:0]                            slot_full;
    logic [SWITCH_CORE_SIZE-1:0]                            take;
    logic [SWITCH_CORE_SIZE-1:0]                            match;
    logic [SWITCH_CORE_SIZE-1:0][SWITCH_CORE_ADDR_SIZE-1:0] slot_dst;
    payload_t [SWITCH_CORE_SIZE-1:0]                        slot_data;

    for (genvar s = 0; s < SWITCH_CORE_SIZE; s++) begin : g_slot
        vec_switch_slot u_slot (
            .clock      (clock),
            .reset      (reset),
            .send_ready (switch_send_ready[s]),
            .send_dst   (switch_send_core_idx[s]),
            .send_data  (switch_send_data[s]),
            .take       (take[s]),
            .full       (slot_full[s]),
            .dst        (slot_dst[s]),
            .data       (slot_data[s]),
            .send_ok    (switch_send_ok[s])
        );
    end

    // A slot names exactly one destination, so at most one receiver can ever claim it.
    always_comb begin
        match = '0;
        take  = '0;
        for (int r = 0; r < SWITCH_CORE_SIZE; r++) begin
            if (switch_recv_request[r] && !switch_recv_ready[r] &&
                int'(switch_recv_core_idx[r]) < SWITCH_CORE_SIZE) begin
                if (slot_full[switch_recv_core_idx[r]] &&
                    slot_dst[switch_recv_core_idx[r]] == SWITCH_CORE_ADDR_SIZE'(r)) begin
                    match[r]                       = 1'b1;
                    take[switch_recv_core_idx[r]]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            switch_recv_ready <= '0;
            switch_recv_data  <= '0;
        end else begin
            switch_recv_ready <= match;
            for (int r = 0; r < SWITCH_CORE_SIZE; r++) begin
                if (match[r]) begin
                    switch_recv_data[r] <= slot_data[switch_recv_core_idx[r]];
                end
            end
        end
    end

endmodule

// File: tb/tb_vec_switch.sv
// tb/tb_vec_switch.sv - scoreboard bench for vec_switch
module tb_vec_switch;
    import switch_pkg::*;

    localparam int N = SWITCH_CORE_SIZE;
    localparam int A = SWITCH_CORE_ADDR_SIZE;
    typedef logic [SWITCH_WIDTH*WORD_BITS-1:0] flat_t;

    typedef struct {
        int    r;
        int    src;
        flat_t data;
        int    cyc;
    } exp_t;

    logic                                  clock = 1'b0;
    logic                                  reset = 1'b0;
    logic [N-1:0]                          switch_send_ready;
    logic [N-1:0][A-1:0]                   switch_send_core_idx;
    logic [N-1:0][SWITCH_WIDTH-1:0][WORD_BITS-1:0] switch_send_data;
    logic [N-1:0]                          switch_send_ok;
    logic [N-1:0]                          switch_recv_request;
    logic [N-1:0][A-1:0]                   switch_recv_core_idx;
    logic [N-1:0]                          switch_recv_ready;
    logic [N-1:0][SWITCH_WIDTH-1:0][WORD_BITS-1:0] switch_recv_data;

    vec_switch dut (
        .clock                (clock),
        .reset                (reset),
        .switch_send_ready    (switch_send_ready),
        .switch_send_core_idx (switch_send_core_idx),
        .switch_send_data     (switch_send_data),
        .switch_send_ok       (switch_send_ok),
        .switch_recv_request  (switch_recv_request),
        .switch_recv_core_idx (switch_recv_core_idx),
        .switch_recv_ready    (switch_recv_ready),
        .switch_recv_data     (switch_recv_data)
    );

    always #5 clock = ~clock;

    int   total  = 0;
    int   bad    = 0;
    int   cyc    = 0;
    int   pulses = 0;
    exp_t sb[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input flat_t got, input flat_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic word_t fbits(input int n);
        int e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    function automatic flat_t float_lanes();
        flat_t f;
        for (int k = 0; k < SWITCH_WIDTH; k++) f[k*WORD_BITS +: WORD_BITS] = fbits(k + 1);
        return f;
    endfunction

    function automatic flat_t pat(input int n);
        flat_t f;
        for (int k = 0; k < SWITCH_WIDTH; k++)
            f[k*WORD_BITS +: WORD_BITS] = 32'((n << 16) ^ (k * 257) ^ 32'hA5000000);
        return f;
    endfunction

    // Every ready pulse must match the oldest queued expectation: receiver, source ack, payload, cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (switch_recv_ready != '0 || switch_send_ok != '0) begin
                check_val("ok_vs_ready_count", $countones(switch_send_ok), $countones(switch_recv_ready));
                for (int r = 0; r < N; r++) begin
                    if (switch_recv_ready[r]) begin
                        pulses++;
                        if (sb.size() == 0) begin
                            check_val("unexpected_ready_r", r, N);
                        end else begin
                            e = sb.pop_front();
                            check_val("recv_port", r, e.r);
                            check_val("send_ok_src", switch_send_ok[e.src], 1);
                            check_val("recv_data", switch_recv_data[r], e.data);
                            check_val("recv_cycle", cyc, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check_val("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic send(input int s, input int dst, input flat_t d);
        switch_send_ready[s]    = 1'b1;
        switch_send_core_idx[s] = A'(dst);
        switch_send_data[s]     = d;
    endtask

    task automatic req(input int r, input int src);
        switch_recv_request[r]  = 1'b1;
        switch_recv_core_idx[r] = A'(src);
    endtask

    task automatic expect_rx(input int r, input int src, input flat_t d, input int at);
        exp_t e;
        e.r = r; e.src = src; e.data = d; e.cyc = at;
        sb.push_back(e);
    endtask

    initial begin
        int c;
        int c2;
        int p0;
        flat_t fl;
        fl = float_lanes();

        switch_send_ready    = $urandom;
        switch_recv_request  = $urandom;
        switch_send_core_idx = $urandom;
        switch_recv_core_idx = $urandom;
        for (int s = 0; s < N; s++)
            for (int k = 0; k < SWITCH_WIDTH; k++) switch_send_data[s][k] = $urandom;
        repeat (2) @(posedge clock);
        step();
        check_val("rst_send_ok", switch_send_ok, 0);
        check_val("rst_recv_ready", switch_recv_ready, 0);
        for (int r = 0; r < N; r++) check_val("rst_recv_data", switch_recv_data[r], 0);
        switch_send_ready    = '0;
        switch_recv_request  = '0;
        switch_send_core_idx = '0;
        switch_recv_core_idx = '0;
        switch_send_data     = '0;
        reset = 1'b1;
        step();

        // Send with nobody requesting: slot must sit FULL and silent.
        send(0, 1, pat(1));
        step();
        switch_send_ready[0] = 1'b0;
        p0 = pulses;
        repeat (20) step();
        check_val("idle_pulses", pulses - p0, 0);
        c = cyc;
        req(1, 0);
        expect_rx(1, 0, pat(1), c + 1);
        drain(10);
        switch_recv_request[1] = 1'b0;
        step();

        c = cyc;
        send(0, 2, fl);
        req(2, 0);
        expect_rx(2, 0, fl, c + 2);
        step();
        switch_send_ready[0] = 1'b0;
        switch_send_data[0]  = ~fl;
        drain(10);
        switch_recv_request[2] = 1'b0;
        repeat (3) step();
        check_val("hold_data", switch_recv_data[2], fl);
        check_val("float_lane0", switch_recv_data[2][0], 32'h3F800000);
        check_val("float_lane15", switch_recv_data[2][15], 32'h41800000);

        c = cyc;
        req(3, 1);
        repeat (5) step();
        send(1, 3, pat(30));
        expect_rx(3, 1, pat(30), c + 7);
        step();
        switch_send_data[1]  = pat(31);
        switch_send_ready[1] = 1'b0;
        drain(10);
        switch_recv_request[3] = 1'b0;
        step();

        // Core 3 asks for src 1 first but the slot names core 2: only core 2 may receive.
        req(3, 1);
        step();
        send(1, 2, pat(40));
        step();
        switch_send_ready[1] = 1'b0;
        repeat (3) step();
        c2 = cyc;
        req(2, 1);
        expect_rx(2, 1, pat(40), c2 + 1);
        drain(10);
        switch_recv_request = '0;
        repeat (3) step();

        c = cyc;
        send(0, 1, pat(50)); send(1, 0, pat(51)); send(2, 2, pat(52)); send(3, 3, pat(53));
        req(0, 1); req(1, 0); req(2, 2); req(3, 3);
        expect_rx(0, 1, pat(51), c + 2);
        expect_rx(1, 0, pat(50), c + 2);
        expect_rx(2, 2, pat(52), c + 2);
        expect_rx(3, 3, pat(53), c + 2);
        step();
        switch_send_ready = '0;
        drain(10);
        switch_recv_request = '0;
        step();

        // Back-to-back self-send: captures land on every third cycle.
        c = cyc;
        req(0, 0);
        for (int k = 0; k < 5; k++) expect_rx(0, 0, pat(c + 3 * k), c + 3 * k + 2);
        for (int t = 0; t < 14; t++) begin
            send(0, 0, pat(cyc));
            step();
        end
        switch_send_ready[0]   = 1'b0;
        switch_recv_request[0] = 1'b0;
        drain(5);
        p0 = pulses;
        repeat (4) step();
        check_val("b2b_no_extra", pulses - p0, 0);

        send(0, 1, pat(200));
        step();
        switch_send_ready[0] = 1'b0;
        p0 = pulses;
        reset = 1'b0;
        step();
        reset = 1'b1;
        req(1, 0);
        repeat (6) step();
        check_val("rst_no_ack", pulses - p0, 0);
        check_val("rst_data_clr", switch_recv_data[1], 0);
        c = cyc;
        send(0, 1, pat(201));
        expect_rx(1, 0, pat(201), c + 2);
        step();
        switch_send_ready[0] = 1'b0;
        drain(10);
        switch_recv_request = '0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/vec_switch.md
Name: vec_switch

Overview:
- Inter-core data switch for the vector cluster.
- Connects the switch send/receive ports of SWITCH_CORE_SIZE vector cores, acting as the receiving side of every core's send port and the sending side of every core's receive port.
- Each source core owns a one-entry holding slot. A payload moves from slot to receiver only when the receiver explicitly requests that source.
- Matched transfers complete with single-cycle ack pulses to both ends.

Parameters:
- SWITCH_CORE_SIZE, 4: number of attached cores.
- SWITCH_WIDTH, 16: lanes per payload.
- WORD_BITS, 32: lane width (IEEE-754 single bit pattern).
- SWITCH_CORE_ADDR_SIZE, $clog2(SWITCH_CORE_SIZE): core index width (derived).

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clock edge).
- switch_send_ready  input  [SWITCH_CORE_SIZE]  core s offers a payload (level, held until ack).
- switch_send_core_idx  input  [SWITCH_CORE_SIZE][SWITCH_CORE_ADDR_SIZE]  destination core of s.
- switch_send_data  input  [SWITCH_CORE_SIZE][SWITCH_WIDTH][WORD_BITS]  payload of s.
- switch_send_ok  output  [SWITCH_CORE_SIZE]  one-cycle pulse: payload of s delivered.
- switch_recv_request  input  [SWITCH_CORE_SIZE]  core r wants a payload (level, held until ack).
- switch_recv_core_idx  input  [SWITCH_CORE_SIZE][SWITCH_CORE_ADDR_SIZE]  source core r accepts from.
- switch_recv_ready  output  [SWITCH_CORE_SIZE]  one-cycle pulse: switch_recv_data[r] valid.
- switch_recv_data  output  [SWITCH_CORE_SIZE][SWITCH_WIDTH][WORD_BITS]  delivered payload, held until next delivery to r.

Behaviour:
- Reset (reset==0 at an edge):
  - All slots go to EMPTY.
  - switch_send_ok, switch_recv_ready, and all switch_recv_data bits go to 0.
  - Reset mid-transfer discards held payloads; no ack is issued.
- Per-source slot FSM, states EMPTY / FULL / ACK:
  - EMPTY: if switch_send_ready[s], latch dst and data, go to FULL; otherwise stay.
  - FULL: switch_send_ready and data are ignored (slot is the captured copy). On match, go to ACK.
  - ACK: switch_send_ok[s]=1 for exactly this cycle. switch_send_ready[s] is ignored. Next state EMPTY.
  - switch_send_ok is a registered, state-decoded output.
- Match for receiver r, evaluated each cycle:
  - switch_recv_request[r]==1 and switch_recv_ready[r]==0.
  - slot[i] is FULL, where i = switch_recv_core_idx[r].
  - slot[i].dst == r.
- On a match (registered at the next edge):
  - switch_recv_data[r] <= slot[i].data.
  - switch_recv_ready[r] <= 1 for one cycle.
  - slot[i] -> ACK. switch_send_ok[i] and switch_recv_ready[r] are high in the same cycle.
- Latency: send_ready and recv_request both high in cycle 0 gives FULL in cycle 1, and ok/ready pulses in cycle 2. Minimum 2 cycles per transfer.
- Throughput: one transfer per source every 3 cycles (EMPTY -> FULL -> ACK).
- Boundary cases:
  - Each slot has one dst, so at most one receiver can match a given source and no arbitration is needed.
  - Different (src, dst) pairs transfer in parallel in the same cycle.
  - Self-send (dst == s) is legal.
  - Request for a source whose slot targets another core, or is EMPTY: receiver waits indefinitely with no timeout. The slot stays FULL.
  - Index >= SWITCH_CORE_SIZE (non-power-of-two size) never matches.
  - Request arriving before the send: the match fires as soon as the slot becomes FULL.
  - switch_recv_request is ignored in the cycle switch_recv_ready is high, so a core reacting to the pulse cannot double-receive.

Decomposition:
- Shared package switch_pkg:
  - word_t (logic [WORD_BITS-1:0]).
  - payload_t (word_t [SWITCH_WIDTH-1:0]).
  - slot_state_t enum {EMPTY, FULL, ACK}.
- Sub-module vec_switch_slot: one per source; holds the FSM, dst, and payload, and exposes full/dst/data plus a take input.
- Top level: match logic and per-receiver output registers.

Test Plan (SWITCH_CORE_SIZE=4, SWITCH_WIDTH=16):
- Reset held 0 for 2 cycles with random inputs -> all ok/ready 0 and recv_data all zero; release and send 0->1 with no request -> no pulses for 20 cycles.
- Core 0 sends lanes 1.0..16.0 to core 2; core 2 requests src 0 in the same cycle -> send_ok[0] and recv_ready[2] both high exactly 2 cycles later; recv_data[2] lane k == k+1.0; data then held stable.
- Core 3 requests src 1 at cycle 0; core 1 sends to 3 at cycle 5 -> pulses at cycle 7; core 1 changes send_data while FULL -> delivered data equals the value captured at cycle 5.
- Core 1 sends to 2 while core 2 requests src 1 only after core 3 requests src 1 first -> core 3 never receives; core 2 receives at its request+1 edge.
- Parallel: 0->1, 1->0, 2->2 (self), 3->3 all matched at cycle 0 -> four send_ok and four recv_ready pulses all in cycle 2.
- Core 0 holds send_ready and recv_request continuously, sending back-to-back -> exactly one delivery per 3 cycles, no duplicates; reset asserted while slot 0 is FULL -> no ack and slot EMPTY afterwards.
